// File: rtl/tmp_seq.sv
// Conversion sequencer: settles, counts comparator decisions over N sample ticks,
// and holds the result for a ready/valid handshake. Includes a sample-tick timeout.
module tmp_seq #(
    parameter int unsigned TOUT = 63,
    parameter int unsigned RW   = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    osr_sel,
    input  logic [3:0]    settle,
    input  logic          sample_tick,
    input  logic          cmp,
    output logic          eng_rst,
    output logic          busy,
    output logic [RW-1:0] result,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          err
);

    localparam int unsigned TW = (TOUT < 2) ? 1 : $clog2(TOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVERT,
        S_HOLD,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    osr_q, osr_d;
    logic [3:0]    settle_q, settle_d;
    logic [3:0]    set_cnt_q, set_cnt_d;
    logic [9:0]    smp_cnt_q, smp_cnt_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] result_q, result_d;
    logic          eng_rst_q, eng_rst_d;
    logic          busy_q, busy_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;

    logic [9:0]    n_target;
    logic [3:0]    settle_len;

    always_comb begin
        state_d     = state_q;
        osr_d       = osr_q;
        settle_d    = settle_q;
        set_cnt_d   = set_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        tout_d      = tout_q;
        acc_d       = acc_q;
        result_d    = result_q;
        n_target    = 10'd64 << osr_q;
        settle_len  = (settle_q == 4'd0) ? 4'd1 : settle_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    osr_d     = osr_sel;
                    settle_d  = settle;
                    set_cnt_d = '0;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (set_cnt_q + 4'd1 >= settle_len) begin
                    state_d   = S_CONVERT;
                    acc_d     = '0;
                    smp_cnt_d = '0;
                    tout_d    = '0;
                end else begin
                    set_cnt_d = set_cnt_q + 4'd1;
                end
            end
            S_CONVERT: begin
                // Priority: abort, then a tick (which also rescues a coincident timeout).
                if (abort) begin
                    state_d = S_IDLE;
                end else if (sample_tick) begin
                    smp_cnt_d = smp_cnt_q + 10'd1;
                    acc_d     = acc_q + RW'(cmp);
                    tout_d    = '0;
                    if (smp_cnt_q + 10'd1 == n_target) begin
                        result_d = acc_q + RW'(cmp);
                        state_d  = S_HOLD;
                    end
                end else if (32'(tout_q) + 32'd1 >= TOUT) begin
                    state_d = S_ERROR;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs registered from the next state so they align with the state register.
        eng_rst_d   = (state_d == S_IDLE) || (state_d == S_HOLD) || (state_d == S_ERROR);
        busy_d      = (state_d == S_SETTLE) || (state_d == S_CONVERT);
        res_valid_d = (state_d == S_HOLD);
        err_d       = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            osr_q       <= '0;
            settle_q    <= '0;
            set_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            tout_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            eng_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            osr_q       <= osr_d;
            settle_q    <= settle_d;
            set_cnt_q   <= set_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            tout_q      <= tout_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            eng_rst_q   <= eng_rst_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign eng_rst   = eng_rst_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

endmodule

// File: doc/tmp_seq.md
TMP_SEQ -- requirements
Module: tmp_seq

Interface
REQ-001 Parameter TOUT, default 63, max cycles between sample_tick strobes before timeout.
REQ-002 Parameter RW, default 10, result width; SHALL hold 0..512.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk only.
REQ-005 start  input  1  request one conversion; level sampled per cycle.
REQ-006 abort  input  1  cancel conversion in progress.
REQ-007 osr_sel  input  2  sample count N: 0->64, 1->128, 2->256, 3->512.
REQ-008 settle  input  4  settling cycles before sampling (0..15).
REQ-009 sample_tick  input  1  one-cycle strobe from phase engine: comparator decision final.
REQ-010 cmp  input  1  comparator decision, valid when sample_tick=1.
REQ-011 eng_rst  output  1  holds phase engine in reset.
REQ-012 busy  output  1  high in SETTLE and CONVERT.
REQ-013 result  output  RW  count of cmp=1 decisions in last conversion.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 err  output  1  sample_tick timeout occurred.

Function
REQ-017 States SHALL be IDLE, SETTLE, CONVERT, HOLD, ERROR; all outputs registered.
REQ-018 IDLE: eng_rst=1, busy=0; start=1 -> latch osr_sel, settle into config regs, load settle counter, next state SETTLE.
REQ-019 Config regs SHALL NOT change outside IDLE/ERROR start acceptance; input changes mid-conversion ignored.
REQ-020 SETTLE: eng_rst=0, busy=1; sample_tick ignored; lasts max(settle,1) cycles, then CONVERT with acc=0, sample count=0, timeout count=0.
REQ-021 CONVERT: eng_rst=0, busy=1; each sample_tick increments sample count, adds cmp to acc (RW-bit, no wrap possible since acc<=N<=512).
REQ-022 Tick number N SHALL be included; on it result<=final acc, next state HOLD, res_valid=1 in first HOLD cycle.
REQ-023 Timeout counter SHALL clear on each sample_tick, increment otherwise; reaching TOUT -> ERROR, acc discarded.
REQ-024 Tick and timeout in same cycle: tick wins, counter clears.
REQ-025 HOLD: eng_rst=1, busy=0, res_valid=1, result stable; res_ready=1 -> IDLE, res_valid=0 next cycle; start ignored in HOLD.
REQ-026 result SHALL keep last value after handshake until next completed conversion.
REQ-027 abort=1 in SETTLE or CONVERT -> IDLE next cycle, no result, res_valid stays 0; abort beats completing tick and timeout in same cycle.
REQ-028 abort ignored in IDLE, HOLD, ERROR.
REQ-029 ERROR: err=1, eng_rst=1, busy=0; start=1 -> err=0, latch config, SETTLE as REQ-018.
REQ-030 start held high SHALL start at most one conversion per return to IDLE/ERROR; back-to-back conversions via held start allowed.

Reset
REQ-031 reset=1 at any clock edge, any state, SHALL force IDLE next cycle; overrides start, abort, sample_tick.
REQ-032 Reset values: eng_rst=1, busy=0, result=0, res_valid=0, err=0, acc=0, all counters=0, config regs osr_sel=0, settle=0.
REQ-033 Reset mid-HOLD SHALL drop res_valid without handshake; result cleared to 0.

Verification
REQ-034 osr_sel=0, settle=3, start pulse, ticks every 4 cycles with cmp=1 on 20 of 64 -> busy high 3 SETTLE cycles, result=20, res_valid until res_ready.
REQ-035 osr_sel=3, cmp=1 every tick -> result=512, no overflow; osr_sel=0 cmp=0 -> result=0.
REQ-036 CONVERT, no tick for 63 cycles -> err=1, eng_rst=1; then start -> err=0, SETTLE entered.
REQ-037 abort asserted coincident with 64th tick -> IDLE, res_valid never high, result unchanged from prior conversion.
REQ-038 res_valid high, res_ready low 10 cycles, start high -> result stable, no new conversion; res_ready -> IDLE then new conversion starts.
REQ-039 reset pulsed mid-CONVERT and mid-HOLD -> all outputs at REQ-032 values next cycle.
